// File: rtl/display_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_controller
//  Description : Multiplexed 8-digit display scanner. Cycles through the
//                digits enabled in digit_mask, lighting each one for TICK_DIV
//                clocks with an optional all-off gap between digits. Strobes
//                are active-low and registered.
//  Revision    : 1.0  initial release
// ============================================================================
module display_scan_controller #(
   parameter int TICK_DIV     = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [7:0] digit_mask,
   output logic [2:0] sel,
   output logic [7:0] anode,
   output logic       frame_done
);

   localparam logic [1:0]  c_IDLE  = 2'd0;
   localparam logic [1:0]  c_SHOW  = 2'd1;
   localparam logic [1:0]  c_BLANK = 2'd2;

   localparam logic [19:0] c_TICK_LAST  = 20'(TICK_DIV - 1);
   localparam logic [7:0]  c_BLANK_LAST = 8'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
   localparam bit          c_HAS_BLANK  = (BLANK_CYCLES > 0);

   logic [1:0]  r_state;
   logic [2:0]  r_sel;
   logic [7:0]  r_anode;
   logic        r_frame_done;
   logic [19:0] r_presc;
   logic [7:0]  r_blank_cnt;

   logic        w_mask_any;
   logic [2:0]  w_first_sel;
   logic [2:0]  w_next_sel;
   logic [7:0]  w_first_anode;
   logic [7:0]  w_next_anode;
   logic        w_wrap;

   // Digit search: lowest set bit for a fresh start, and the first set bit
   // above the current digit (wrapping) for an advance. Iterating from the far
   // end lets the nearest candidate overwrite the farther ones.
   always_comb begin
      w_mask_any  = |digit_mask;
      w_first_sel = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (digit_mask[i]) w_first_sel = 3'(i);
      end
      w_next_sel = r_sel;
      for (int k = 8; k >= 1; k--) begin
         if (digit_mask[3'(r_sel + 3'(k))]) w_next_sel = 3'(r_sel + 3'(k));
      end
      w_first_anode = ~(8'h01 << w_first_sel);
      w_next_anode  = ~(8'h01 << w_next_sel);
      // A new digit at or below the old index means the scan wrapped around.
      w_wrap        = (w_next_sel <= r_sel);
   end

   // Scan state machine with registered strobe, select and frame pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= c_IDLE;
         r_sel        <= 3'd0;
         r_anode      <= 8'hFF;
         r_frame_done <= 1'b0;
         r_presc      <= 20'd0;
         r_blank_cnt  <= 8'd0;
      end else if (!en) begin
         r_state      <= c_IDLE;
         r_sel        <= 3'd0;
         r_anode      <= 8'hFF;
         r_frame_done <= 1'b0;
         r_presc      <= 20'd0;
         r_blank_cnt  <= 8'd0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (w_mask_any) begin
                  r_state <= c_SHOW;
                  r_sel   <= w_first_sel;
                  r_anode <= w_first_anode;
                  r_presc <= 20'd0;
               end
            end
            c_SHOW: begin
               if (r_presc == c_TICK_LAST) begin
                  r_presc <= 20'd0;
                  if (!w_mask_any) begin
                     r_state <= c_IDLE;
                     r_sel   <= 3'd0;
                     r_anode <= 8'hFF;
                  end else if (c_HAS_BLANK) begin
                     r_state     <= c_BLANK;
                     r_anode     <= 8'hFF;
                     r_blank_cnt <= 8'd0;
                  end else begin
                     r_sel        <= w_next_sel;
                     r_anode      <= w_next_anode;
                     r_frame_done <= w_wrap;
                  end
               end else begin
                  r_presc <= r_presc + 20'd1;
               end
            end
            c_BLANK: begin
               if (r_blank_cnt == c_BLANK_LAST) begin
                  r_blank_cnt <= 8'd0;
                  if (!w_mask_any) begin
                     r_state <= c_IDLE;
                     r_sel   <= 3'd0;
                  end else begin
                     r_state      <= c_SHOW;
                     r_sel        <= w_next_sel;
                     r_anode      <= w_next_anode;
                     r_presc      <= 20'd0;
                     r_frame_done <= w_wrap;
                  end
               end else begin
                  r_blank_cnt <= r_blank_cnt + 8'd1;
               end
            end
            default: begin
               r_state     <= c_IDLE;
               r_sel       <= 3'd0;
               r_anode     <= 8'hFF;
               r_presc     <= 20'd0;
               r_blank_cnt <= 8'd0;
            end
         endcase
      end
   end

   assign sel        = r_sel;
   assign anode      = r_anode;
   assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scan_controller
//  Description : Directed self-checking bench for display_scan_controller
//                (TICK_DIV=4; one instance with BLANK_CYCLES=2, one with 0).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_display_scan_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [7:0] digit_mask;
   logic [2:0] sel, sel0;
   logic [7:0] anode, anode0;
   logic       fd, fd0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   display_scan_controller #(.TICK_DIV(4), .BLANK_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .en(en), .digit_mask(digit_mask),
      .sel(sel), .anode(anode), .frame_done(fd)
   );

   display_scan_controller #(.TICK_DIV(4), .BLANK_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .en(en), .digit_mask(digit_mask),
      .sel(sel0), .anode(anode0), .frame_done(fd0)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check3(input string tag, input logic [2:0] s, input logic [7:0] a, input logic f,
                         input logic [2:0] es, input logic [7:0] ea, input logic ef);
      check({tag, ".sel"},   32'(s), 32'(es));
      check({tag, ".anode"}, 32'(a), 32'(ea));
      check({tag, ".fd"},    32'(f), 32'(ef));
   endtask

   // Expected strobe for a digit: active-low one-hot.
   function automatic logic [7:0] strobe(input int d);
      logic [7:0] oh;
      oh = 8'h01 << d;
      return ~oh;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d;
      logic [7:0] lit;
      reset = 1'b1; en = 1'b0; digit_mask = 8'h00;
      #1 reset = 1'b0;
      #1 check3("reset_async", sel, anode, fd, 3'd0, 8'hFF, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check3("idle_after_reset", sel, anode, fd, 3'd0, 8'hFF, 1'b0);
      digit_mask = 8'hFF;
      @(negedge clk);
      check3("idle_en_low", sel, anode, fd, 3'd0, 8'hFF, 1'b0);

      // Full mask: 6-cycle digit slots (4 lit + 2 dark), 48-cycle frame.
      en = 1'b1;
      @(negedge clk);
      for (int t = 0; t < 50; t++) begin
         d = (t / 6) % 8;
         check3($sformatf("full t%0d", t), sel, anode, fd, 3'(d),
                ((t % 6) < 4) ? strobe(d) : 8'hFF, (t % 48 == 0) && (t > 0));
         @(negedge clk);
      end
      en = 1'b0;
      @(negedge clk);
      check3("full_stop", sel, anode, fd, 3'd0, 8'hFF, 1'b0);

      // Sparse mask 2,7 alternating; only digits 2 and 7 may ever be strobed.
      en = 1'b1; digit_mask = 8'b1000_0100; lit = 8'h00;
      @(negedge clk);
      for (int t = 0; t < 37; t++) begin
         d = (((t / 6) % 2) == 0) ? 2 : 7;
         lit = lit | ~anode;
         check3($sformatf("sparse t%0d", t), sel, anode, fd, 3'(d),
                ((t % 6) < 4) ? strobe(d) : 8'hFF, (t % 12 == 0) && (t > 0));
         @(negedge clk);
      end
      check("sparse_lit_digits", 32'(lit), 32'h84);
      en = 1'b0;
      @(negedge clk);

      // Single digit 4: reselected every slot, frame pulse every 6 cycles.
      en = 1'b1; digit_mask = 8'h10;
      @(negedge clk);
      for (int t = 0; t < 25; t++) begin
         check3($sformatf("single t%0d", t), sel, anode, fd, 3'd4,
                ((t % 6) < 4) ? 8'hEF : 8'hFF, (t % 6 == 0) && (t > 0));
         @(negedge clk);
      end
      en = 1'b0;
      @(negedge clk);

      // Enable drop in the middle of digit 3, then restart at lowest set bit.
      en = 1'b1; digit_mask = 8'hFF;
      @(negedge clk);
      for (int t = 0; t < 20; t++) begin
         d = (t / 6) % 8;
         check3($sformatf("pre_drop t%0d", t), sel, anode, fd, 3'(d),
                ((t % 6) < 4) ? strobe(d) : 8'hFF, 1'b0);
         if (t < 19) @(negedge clk);
      end
      en = 1'b0;
      @(negedge clk);
      check3("en_drop", sel, anode, fd, 3'd0, 8'hFF, 1'b0);
      en = 1'b1; digit_mask = 8'h68;
      @(negedge clk);
      check3("re_enable", sel, anode, fd, 3'd3, 8'hF7, 1'b0);
      en = 1'b0;
      @(negedge clk);

      // Mask cleared while digit 5 is lit: digit finishes, then idle.
      en = 1'b1; digit_mask = 8'h20;
      @(negedge clk);
      check3("mclr t0", sel, anode, fd, 3'd5, 8'hDF, 1'b0);
      @(negedge clk);
      digit_mask = 8'h00;
      @(negedge clk);
      check3("mclr t2", sel, anode, fd, 3'd5, 8'hDF, 1'b0);
      @(negedge clk);
      check3("mclr t3", sel, anode, fd, 3'd5, 8'hDF, 1'b0);
      @(negedge clk);
      check3("mclr t4", sel, anode, fd, 3'd0, 8'hFF, 1'b0);
      @(negedge clk);
      check3("mclr t5", sel, anode, fd, 3'd0, 8'hFF, 1'b0);
      en = 1'b0;
      @(negedge clk);

      // Asynchronous reset between edges while a digit is lit.
      en = 1'b1; digit_mask = 8'hFF;
      @(negedge clk);
      check3("arst_pre", sel, anode, fd, 3'd0, 8'hFE, 1'b0);
      #2 reset = 1'b0;
      #1 check3("arst_mid", sel, anode, fd, 3'd0, 8'hFF, 1'b0);
      @(negedge clk);
      check3("arst_held", sel, anode, fd, 3'd0, 8'hFF, 1'b0);
      en = 1'b0; reset = 1'b1;
      @(negedge clk);
      check3("arst_release", sel, anode, fd, 3'd0, 8'hFF, 1'b0);

      // No blanking: digits back-to-back, 32-cycle frame, never all-off.
      en = 1'b1; digit_mask = 8'hFF;
      @(negedge clk);
      for (int t = 0; t < 34; t++) begin
         d = (t / 4) % 8;
         check3($sformatf("noblank t%0d", t), sel0, anode0, fd0, 3'(d),
                strobe(d), (t % 32 == 0) && (t > 0));
         @(negedge clk);
      end
      en = 1'b0;
      @(negedge clk);
      check3("noblank_stop", sel0, anode0, fd0, 3'd0, 8'hFF, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
